game_score_fsm: RTL and testbench

- Game-flow controller directly upstream of the ball controller.
- Generates the 2-bit game `state` that the ball controller consumes; the ball only moves in `play`.
- Consumes the ball controller's `x_ball` to detect goals, keeps both players' scores, inserts a serve pause after each point, and declares a winner.
- Scores and state also feed the VGA overlay/text stage.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/game_score_fsm_edge_detect.sv | 25 ++
 rtl/game_score_fsm.sv | 129 ++++++++++++
 tb/tb_game_score_fsm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA / game types and screen constants used by the game-flow and ball logic.
package vga_pkg;

  // Game phase seen by the ball controller and the display overlay.
  typedef enum logic [1:0] {
    start = 2'd0,
    play  = 2'd1,
    serve = 2'd2,
    over  = 2'd3
  } game_state_t;

  localparam int HOR_PIXELS = 1024;
  localparam int BALL_SIZE  = 15;

  // Left-edge x at or beyond which the ball counts as past the right goal line.
  function automatic logic [10:0] goal_r_threshold(input int edge_margin);
    return 11'(HOR_PIXELS - BALL_SIZE - edge_margin);
  endfunction

endpackage

// File: rtl/game_score_fsm_edge_detect.sv
// Rising-edge detector for synchronised button levels; reset value of the
// history flop is selectable so a button held through reset gives no edge.
module edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev_reg;

  // Remember the previous level of the input every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_reg <= RESET_VAL;
    end else begin
      prev_reg <= din;
    end
  end

  assign rise = din & ~prev_reg;

endmodule

// File: rtl/game_score_fsm.sv
// Game-flow controller: detects goals from the ball position, keeps both
// scores, pauses for a serve after each point and declares the winner.
module game_score_fsm
  import vga_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = 60,
  parameter int EDGE_MARGIN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start_btn,
  input  logic [10:0] x_ball,
  output game_state_t state,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        winner_right
);

  localparam int CW = $clog2(SERVE_TICKS + 1);

  localparam logic [10:0]   GOAL_L_X   = 11'(EDGE_MARGIN);
  localparam logic [10:0]   GOAL_R_X   = goal_r_threshold(EDGE_MARGIN);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_TICKS - 1);

  game_state_t   state_reg;
  logic [3:0]    score_left_reg;
  logic [3:0]    score_right_reg;
  logic          winner_right_reg;
  logic [CW-1:0] serve_cnt_reg;

  logic       start_pulse;
  logic       goal_l;
  logic       goal_r;
  logic [3:0] score_left_inc;
  logic [3:0] score_right_inc;

  // History starts at 1 so a button already held when reset lifts is ignored.
  edge_detect #(
    .RESET_VAL(1'b1)
  ) u_start_edge (
    .clk (clk),
    .rst (rst),
    .din (start_btn),
    .rise(start_pulse)
  );

  // Goal lines are checked every cycle, independent of the frame tick.
  assign goal_l = (x_ball <= GOAL_L_X);
  assign goal_r = (x_ball >= GOAL_R_X);

  assign score_left_inc  = score_left_reg + 4'd1;
  assign score_right_inc = score_right_reg + 4'd1;

  // Game FSM with registered scores, winner flag and serve pause counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= start;
      score_left_reg   <= 4'd0;
      score_right_reg  <= 4'd0;
      winner_right_reg <= 1'b0;
      serve_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        start: begin
          if (start_pulse) begin
            score_left_reg   <= 4'd0;
            score_right_reg  <= 4'd0;
            winner_right_reg <= 1'b0;
            state_reg        <= play;
          end
        end

        play: begin
          // Leaving play makes the ball controller re-centre the ball, so a
          // goal held for several cycles is still counted only once.
          if (goal_l) begin
            score_right_reg <= score_right_inc;
            if (score_right_inc == WIN) begin
              winner_right_reg <= 1'b1;
              state_reg        <= over;
            end else begin
              serve_cnt_reg <= '0;
              state_reg     <= serve;
            end
          end else if (goal_r) begin
            score_left_reg <= score_left_inc;
            if (score_left_inc == WIN) begin
              winner_right_reg <= 1'b0;
              state_reg        <= over;
            end else begin
              serve_cnt_reg <= '0;
              state_reg     <= serve;
            end
          end
        end

        serve: begin
          if (timing_tick) begin
            if (serve_cnt_reg == SERVE_LAST) begin
              state_reg <= play;
            end else begin
              serve_cnt_reg <= serve_cnt_reg + CW'(1);
            end
          end
        end

        over: begin
          // Final score stays on screen until the next game actually starts.
          if (start_pulse) begin
            state_reg <= start;
          end
        end

        default: begin
          state_reg <= start;
        end
      endcase
    end
  end

  assign state        = state_reg;
  assign score_left   = score_left_reg;
  assign score_right  = score_right_reg;
  assign winner_right = winner_right_reg;

endmodule

// File: tb/tb_game_score_fsm.sv
// Directed test of the game-flow controller with hand-computed expectations.
module tb_game_score_fsm;
  import vga_pkg::*;

  localparam int ST_START = 0;
  localparam int ST_PLAY  = 1;
  localparam int ST_SERVE = 2;
  localparam int ST_OVER  = 3;
  localparam logic [10:0] MID_X = 11'd500;

  logic        clk;
  logic        rst;
  logic        timing_tick;
  logic        start_btn;
  logic [10:0] x_ball;
  game_state_t state;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic        winner_right;

  int errors;
  int checks;

  game_score_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .timing_tick (timing_tick),
    .start_btn   (start_btn),
    .x_ball      (x_ball),
    .state       (state),
    .score_left  (score_left),
    .score_right (score_right),
    .winner_right(winner_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic goal(input logic [10:0] xv);
    x_ball = xv;
    step();
    x_ball = MID_X;
    $display("goal x=%0d -> state=%0d score=%0d:%0d winner_right=%0d",
             xv, int'(state), score_left, score_right, winner_right);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      timing_tick = 1'b1;
      step();
      timing_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b0;
    timing_tick = 1'b0;
    start_btn   = 1'b1;
    x_ball      = MID_X;

    // Reset held, button held high throughout.
    step();
    step();
    check("rst_state", int'(state), ST_START);
    check("rst_score_l", score_left, 0);
    check("rst_score_r", score_right, 0);
    check("rst_winner", winner_right, 0);
    rst = 1'b1;
    step();
    step();
    step();
    check("held_btn_no_start", int'(state), ST_START);

    // Release then press: play one cycle after the rising edge.
    start_btn = 1'b0;
    step();
    check("before_edge", int'(state), ST_START);
    start_btn = 1'b1;
    step();
    check("start_to_play", int'(state), ST_PLAY);
    check("play_score_l0", score_left, 0);
    check("play_score_r0", score_right, 0);
    start_btn = 1'b0;

    // Ball on the left goal line for 3 cycles counts once.
    x_ball = 11'd8;
    step();
    check("goal_l_state", int'(state), ST_SERVE);
    check("goal_l_score_r", score_right, 1);
    step();
    step();
    x_ball = MID_X;
    check("goal_l_once", score_right, 1);
    check("goal_l_score_l", score_left, 0);

    // Serve pause: start pulses and non-tick cycles do nothing; play on 60th tick.
    press_start();
    check("serve_ignores_start", int'(state), ST_SERVE);
    ticks(59);
    check("serve_59_ticks", int'(state), ST_SERVE);
    timing_tick = 1'b1;
    step();
    timing_tick = 1'b0;
    check("serve_60th_tick", int'(state), ST_PLAY);

    // Right threshold boundary.
    x_ball = 11'd1000;
    step();
    step();
    x_ball = MID_X;
    check("x1000_no_goal_state", int'(state), ST_PLAY);
    check("x1000_no_goal_score", score_left, 0);
    goal(11'd1001);
    check("x1001_score_l", score_left, 1);
    check("x1001_state", int'(state), ST_SERVE);
    ticks(60);
    check("serve2_done", int'(state), ST_PLAY);

    // Left player runs to 4, then the winning point.
    for (int k = 2; k <= 4; k++) begin
      goal(11'd1500);
      check("left_run_score", score_left, k);
      ticks(60);
    end
    check("pre_win_state", int'(state), ST_PLAY);
    goal(11'd1001);
    check("win_score_l", score_left, 5);
    check("win_state", int'(state), ST_OVER);
    check("win_right_flag", winner_right, 0);
    goal(11'd0);
    goal(11'd1020);
    check("over_hold_l", score_left, 5);
    check("over_hold_r", score_right, 1);
    check("over_hold_state", int'(state), ST_OVER);

    // Over -> start keeps scores; start -> play clears them.
    press_start();
    check("over_to_start", int'(state), ST_START);
    check("start_keeps_l", score_left, 5);
    check("start_keeps_r", score_right, 1);
    press_start();
    check("restart_play", int'(state), ST_PLAY);
    check("restart_l", score_left, 0);
    check("restart_r", score_right, 0);

    // Build 2:3 and stop mid-serve with counter at 30, then async reset.
    goal(11'd0);    ticks(60);
    goal(11'd1001); ticks(60);
    goal(11'd3);    ticks(60);
    goal(11'd1001); ticks(60);
    goal(11'd0);
    check("mid_score_l", score_left, 2);
    check("mid_score_r", score_right, 3);
    ticks(30);
    check("mid_serve", int'(state), ST_SERVE);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_state", int'(state), ST_START);
    check("async_rst_l", score_left, 0);
    check("async_rst_r", score_right, 0);
    check("async_rst_win", winner_right, 0);
    step();
    rst = 1'b1;
    step();

    // Right player wins 5:0.
    press_start();
    check("game2_play", int'(state), ST_PLAY);
    for (int k = 1; k <= 4; k++) begin
      goal(11'd2);
      check("right_run_score", score_right, k);
      ticks(60);
    end
    goal(11'd8);
    check("right_win_score", score_right, 5);
    check("right_win_state", int'(state), ST_OVER);
    check("right_win_flag", winner_right, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
